// File: rtl/merge_pkg.sv
// merge_pkg: shared constants and helpers for merge_rr_buffered.
//   index_width(n)  : width of a channel index, max(1, clog2(n))
//   MERGE_BUF_DEPTH : number of entries in the output buffer
package merge_pkg;

    localparam int unsigned MERGE_BUF_DEPTH = 2;

    function automatic int unsigned index_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/merge_rr_buffered_if.sv
// merge_rr_buffered_if: handshake bundle between N producers, the merge and
// one consumer.
//   ins/ins_valid/ins_ready    : SIZE input channels, channel i at [i*DATA_TYPE +: DATA_TYPE]
//   outs/outs_valid/outs_ready : merged output channel
//   index                      : source channel of the token on outs
// Modports: slave = the merge, master = the surrounding producers/consumer.
interface merge_rr_buffered_if
    import merge_pkg::*;
#(
    parameter int unsigned SIZE        = 2,
    parameter int unsigned DATA_TYPE   = 32,
    parameter int unsigned INDEX_WIDTH = index_width(SIZE)
) ();

    logic [SIZE*DATA_TYPE-1:0] ins;
    logic [SIZE-1:0]           ins_valid;
    logic [SIZE-1:0]           ins_ready;
    logic [DATA_TYPE-1:0]      outs;
    logic                      outs_valid;
    logic                      outs_ready;
    logic [INDEX_WIDTH-1:0]    index;

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid, index
    );

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid, index
    );

endinterface

// File: rtl/merge_rr_arbiter.sv
// merge_rr_arbiter: picks one requesting channel.
//   req         : per-channel request
//   ptr         : round-robin start position (ignored in fixed-priority builds)
//   en          : grant permitted this cycle
//   grant       : one-hot grant (all zero when disabled or no request)
//   grant_idx   : encoded winner
//   grant_valid : a grant is issued
// MERGE_RR_FAIR_EN defined selects round-robin from ptr; undefined selects
// lowest-index-wins.
module merge_rr_arbiter #(
    parameter int unsigned SIZE        = 2,
    parameter int unsigned INDEX_WIDTH = 1
) (
    input  logic [SIZE-1:0]        req,
    input  logic [INDEX_WIDTH-1:0] ptr,
    input  logic                   en,
    output logic [SIZE-1:0]        grant,
    output logic [INDEX_WIDTH-1:0] grant_idx,
    output logic                   grant_valid
);

`ifndef MERGE_RR_FAIR_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    always_comb begin
        int unsigned sel;
        int unsigned win;
        logic        found;
        sel   = 0;
        win   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < SIZE; k++) begin
`ifdef MERGE_RR_FAIR_EN
            sel = (32'(ptr) + k) % SIZE;
`else
            sel = k;
`endif
            // Mask-and-reduce instead of req[sel] keeps the select width-clean.
            if (!found && |(req & (SIZE'(1) << sel))) begin
                found = 1'b1;
                win   = sel;
            end
        end
        grant_valid = found && en;
        grant_idx   = INDEX_WIDTH'(win);
        grant       = grant_valid ? (SIZE'(1) << win) : '0;
    end

endmodule

// File: rtl/merge_rr_buffered.sv
// merge_rr_buffered: registered N-input merge with a two-entry output buffer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : merge_rr_buffered_if.slave (ins/ins_valid/ins_ready,
//              outs/outs_valid/outs_ready, index)
// ins_ready depends only on ins_valid and registered state, never on
// outs_ready. Macro MERGE_RR_FAIR_EN enables round-robin arbitration;
// without it the lowest valid channel wins.
module merge_rr_buffered
    import merge_pkg::*;
#(
    parameter int unsigned SIZE        = 2,
    parameter int unsigned DATA_TYPE   = 32,
    parameter int unsigned INDEX_WIDTH = index_width(SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    merge_rr_buffered_if.slave   bus
);

    logic [DATA_TYPE-1:0]   data_q [MERGE_BUF_DEPTH];
    logic [INDEX_WIDTH-1:0] idx_q  [MERGE_BUF_DEPTH];
    logic [1:0]             count_q;
    logic                   head_q;
    logic [INDEX_WIDTH-1:0] ptr;

    logic                   full;
    logic                   en;
    logic                   push;
    logic                   pop;
    logic                   tail;
    logic [SIZE-1:0]        grant;
    logic [INDEX_WIDTH-1:0] grant_idx;
    logic                   grant_valid;
    logic [DATA_TYPE-1:0]   push_data;

    assign full = (count_q == 2'(MERGE_BUF_DEPTH));
    assign en   = !full && !rst;

    merge_rr_arbiter #(
        .SIZE        (SIZE),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_arb (
        .req         (bus.ins_valid),
        .ptr         (ptr),
        .en          (en),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign bus.ins_ready  = grant;
    assign bus.outs_valid = (count_q != 2'd0);
    assign bus.outs       = data_q[head_q];
    assign bus.index      = idx_q[head_q];

    assign push      = grant_valid;
    assign pop       = bus.outs_valid && bus.outs_ready;
    // Free slot is head+count; never used when full.
    assign tail      = head_q ^ count_q[0];
    assign push_data = DATA_TYPE'(bus.ins >> (32'(grant_idx) * DATA_TYPE));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            head_q  <= 1'b0;
            data_q  <= '{default: '0};
            idx_q   <= '{default: '0};
        end else begin
            if (push) begin
                data_q[tail] <= push_data;
                idx_q[tail]  <= grant_idx;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            if (push && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

`ifdef MERGE_RR_FAIR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= (grant_idx == INDEX_WIDTH'(SIZE - 1)) ? '0
                                                         : grant_idx + INDEX_WIDTH'(1);
        end
    end
`else
    assign ptr = '0;
`endif

endmodule

// File: tb/tb_merge_rr_buffered.sv
// Directed bench for merge_rr_buffered with SIZE=4, DATA_TYPE=8.
// Expected values follow the arbitration mode selected by MERGE_RR_FAIR_EN.
module tb_merge_rr_buffered;

    localparam int unsigned SIZE = 4;
    localparam int unsigned DW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    merge_rr_buffered_if #(.SIZE(SIZE), .DATA_TYPE(DW)) bus ();

    merge_rr_buffered #(.SIZE(SIZE), .DATA_TYPE(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int unsigned e;
        bus.ins        = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.ins_valid  = 4'b1111;
        bus.outs_ready = 1'b1;

        // Reset held three cycles with every input valid.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ins_ready", 32'(bus.ins_ready), 32'h0);
            chk("rst_outs_valid", 32'(bus.outs_valid), 32'h0);
            chk("rst_outs", 32'(bus.outs), 32'h0);
            chk("rst_index", 32'(bus.index), 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(bus.ins_ready), 32'h1);

        // All channels valid, consumer always ready.
        for (int k = 0; k < 8; k++) begin
`ifdef MERGE_RR_FAIR_EN
            e = 32'(k % 4);
`else
            e = 0;
`endif
            chk("stream_ready", 32'(bus.ins_ready), 32'(4'b0001 << e));
            tick();
            chk("stream_valid", 32'(bus.outs_valid), 32'h1);
            chk("stream_index", 32'(bus.index), e);
            chk("stream_outs", 32'(bus.outs), 32'hA0 + e);
        end
        bus.ins_valid = 4'b0000;
        tick();
        chk("drain_empty", 32'(bus.outs_valid), 32'h0);

        // Backpressure: two tokens fill the buffer, head holds.
        bus.outs_ready = 1'b0;
        bus.ins_valid  = 4'b0110;
        #1;
        chk("bp_grant1", 32'(bus.ins_ready), 32'h2);
        tick();
        bus.ins_valid = 4'b0100;
        #1;
        chk("bp_grant2", 32'(bus.ins_ready), 32'h4);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_full_ready", 32'(bus.ins_ready), 32'h0);
            chk("bp_hold_outs", 32'(bus.outs), 32'hA1);
            chk("bp_hold_index", 32'(bus.index), 32'h1);
            chk("bp_hold_valid", 32'(bus.outs_valid), 32'h1);
            tick();
        end
        bus.outs_ready = 1'b1;
        #1;
        chk("bp_full_ignores_outs_ready", 32'(bus.ins_ready), 32'h0);
        bus.ins_valid = 4'b0000;
        tick();
        chk("bp_second_outs", 32'(bus.outs), 32'hA2);
        chk("bp_second_index", 32'(bus.index), 32'h2);
        chk("bp_second_valid", 32'(bus.outs_valid), 32'h1);
        tick();
        chk("bp_drained", 32'(bus.outs_valid), 32'h0);

        // Simultaneous push and pop at count 1.
        bus.outs_ready = 1'b0;
        bus.ins_valid  = 4'b0001;
        bus.ins[7:0]   = 8'hB0;
        tick();
        chk("pp_count_init", 32'(dut.count_q), 32'h1);
        bus.outs_ready = 1'b1;
        bus.ins[7:0]   = 8'hB1;
        #1;
        chk("pp_head0", 32'(bus.outs), 32'hB0);
        tick();
        chk("pp_outs1", 32'(bus.outs), 32'hB1);
        chk("pp_valid1", 32'(bus.outs_valid), 32'h1);
        chk("pp_count1", 32'(dut.count_q), 32'h1);
        bus.ins[7:0] = 8'hB2;
        tick();
        chk("pp_outs2", 32'(bus.outs), 32'hB2);
        chk("pp_valid2", 32'(bus.outs_valid), 32'h1);
        chk("pp_count2", 32'(dut.count_q), 32'h1);
        bus.ins_valid = 4'b0000;
        tick();
        chk("pp_empty", 32'(bus.outs_valid), 32'h0);
        chk("pp_count_end", 32'(dut.count_q), 32'h0);

        // Reset while the buffer is full.
        bus.outs_ready = 1'b0;
        bus.ins[7:0]   = 8'hA0;
        bus.ins_valid  = 4'b1000;
        tick();
        tick();
        chk("mr_full", 32'(dut.count_q), 32'h2);
        rst = 1'b1;
        tick();
        chk("mr_valid", 32'(bus.outs_valid), 32'h0);
        chk("mr_outs", 32'(bus.outs), 32'h0);
        chk("mr_index", 32'(bus.index), 32'h0);
        chk("mr_count", 32'(dut.count_q), 32'h0);
        chk("mr_ins_ready", 32'(bus.ins_ready), 32'h0);
`ifdef MERGE_RR_FAIR_EN
        chk("mr_ptr", 32'(dut.ptr), 32'h0);
`endif
        rst            = 1'b0;
        bus.ins_valid  = 4'b0000;
        bus.outs_ready = 1'b1;
        tick();
        chk("mr_no_stale", 32'(bus.outs_valid), 32'h0);
        bus.ins_valid = 4'b0010;
        tick();
        chk("mr_new_outs", 32'(bus.outs), 32'hA1);
        chk("mr_new_index", 32'(bus.index), 32'h1);
        chk("mr_new_valid", 32'(bus.outs_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
